// File: rtl/mux4_rr_scheduler.sv
// Four-input mux driven by a round-robin arbiter with bounded bursts.
// Select, grant, data and valid are all registered.
module mux4_rr_scheduler #(
  parameter int BURST = 4,
  parameter int CNTW  = 4
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [3:0] REQ,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  output logic [1:0] S,
  output logic [3:0] GNT,
  output logic       Y,
  output logic       VALID
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_n;
  logic [1:0]      ptr, ptr_n;
  logic [1:0]      s_n;
  logic [3:0]      gnt_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [1:0]      base;
  logic [3:0]      rot;
  logic [1:0]      off;
  logic [1:0]      win;
  logic            any;
  logic            hold;
  logic            ymux;

  // Rotate requests so the highest-priority index lands at bit 0.
  always_comb begin
    base = (state == GRANT) ? S + 2'd1 : ptr;
    rot  = 4'({REQ, REQ} >> base);
    any  = |REQ;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             off = 2'd3;
    win  = base + off;
    hold = REQ[S] && (cnt < CNTW'(BURST));
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    s_n     = S;
    gnt_n   = GNT;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n = GRANT;
          s_n     = win;
          gnt_n   = 4'(1) << win;
          cnt_n   = CNTW'(1);
        end
      end
      GRANT: begin
        if (hold) begin
          cnt_n = cnt + CNTW'(1);
        end else begin
          ptr_n = S + 2'd1;
          if (any) begin
            s_n   = win;
            gnt_n = 4'(1) << win;
            cnt_n = CNTW'(1);
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            cnt_n   = '0;
          end
        end
      end
    endcase
  end

  always_comb begin
    unique case (S)
      2'd0: ymux = A;
      2'd1: ymux = B;
      2'd2: ymux = C;
      2'd3: ymux = D;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      ptr   <= 2'd0;
      S     <= 2'd0;
      GNT   <= 4'b0000;
      cnt   <= '0;
      Y     <= 1'b0;
      VALID <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      S     <= s_n;
      GNT   <= gnt_n;
      cnt   <= cnt_n;
      Y     <= ymux;
      VALID <= |GNT;
    end
  end

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Bench for mux4_rr_scheduler: directed scenarios plus random
// traffic against a behavioural round-robin model.
module tb_mux4_rr_scheduler;

  localparam int BURST = 4;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic       C = 1'b0;
  logic       D = 1'b0;
  logic [1:0] S;
  logic [3:0] GNT;
  logic       Y;
  logic       VALID;

  mux4_rr_scheduler #(.BURST(BURST), .CNTW(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ),
    .A(A), .B(B), .C(C), .D(D),
    .S(S), .GNT(GNT), .Y(Y), .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int passed = 0;

  // Model: holder -1 means idle.
  int holder = -1;
  int cnt = 0;
  int ptr = 0;
  int ms = 0;
  bit my = 1'b0;
  bit mv = 1'b0;

  function automatic int search(logic [3:0] r, int from);
    for (int k = 0; k < 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    holder = -1; cnt = 0; ptr = 0; ms = 0; my = 0; mv = 0;
  endtask

  task automatic model_edge();
    logic [3:0] d;
    d = {D, C, B, A};
    mv = (holder >= 0);
    my = d[ms];
    if (holder < 0) begin
      if (REQ != 0) begin
        holder = search(REQ, ptr); cnt = 1; ms = holder;
      end
    end else if (REQ[holder] && cnt < BURST) begin
      cnt++;
    end else begin
      ptr = (holder + 1) % 4;
      if (REQ != 0) begin
        holder = search(REQ, ptr); cnt = 1; ms = holder;
      end else begin
        holder = -1; cnt = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string w);
    logic [3:0] eg;
    eg = (holder < 0) ? 4'b0000 : 4'(1 << holder);
    chk({w, " gnt"}, GNT, eg);
    chk({w, " s"}, {2'b00, S}, 4'(ms));
    chk({w, " valid"}, {3'b000, VALID}, {3'b000, mv});
    chk({w, " y"}, {3'b000, Y}, {3'b000, my});
  endtask

  task automatic step(input logic [3:0] r, input string w);
    REQ = r;
    @(posedge CLK);
    model_edge();
    #1;
    check_all(w);
  endtask

  // Asserts reset between edges, checks, releases on the negedge.
  task automatic mid_reset(input string w);
    #2 RSTN = 1'b0;
    model_reset();
    #1;
    check_all(w);
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  initial begin
    #1;
    model_reset();
    check_all("por");
    @(negedge CLK);
    RSTN = 1'b1;

    // Single requester C with C=1
    C = 1'b1;
    step(4'b0100, "c_lat1");
    chk("c_gnt", GNT, 4'b0100);
    step(4'b0100, "c_lat2");
    chk("c_valid_y", {2'b00, VALID, Y}, 4'b0011);
    step(4'b0000, "c_rel");
    step(4'b0000, "c_idle");

    // All requesting: A x4, B x4, C x4, D x4, A
    mid_reset("rst_all");
    for (int i = 0; i < 18; i++) begin
      A = 1'($urandom); B = 1'($urandom);
      C = 1'($urandom); D = 1'($urandom);
      step(4'b1111, "all");
      chk("all_seq", GNT, 4'(1 << ((i / 4) % 4)));
    end

    // A drops after two grant cycles
    mid_reset("rst_drop");
    step(4'b0011, "drop1");
    step(4'b0011, "drop2");
    step(4'b0010, "drop3");
    chk("drop_b", GNT, 4'b0010);

    // Lone requester D re-granted across burst boundaries
    mid_reset("rst_lone");
    for (int i = 0; i < 10; i++) begin
      step(4'b1000, "lone");
      chk("lone_gnt", GNT, 4'b1000);
    end

    // Reset mid-burst on B, pointer returns to A
    mid_reset("rst_mid");
    step(4'b0010, "mid1");
    step(4'b0010, "mid2");
    mid_reset("mid_abort");
    step(4'b1111, "mid_after");
    chk("mid_ptr0", GNT, 4'b0001);

    // Data path: each requester in turn
    mid_reset("rst_data");
    A = 1'b1; B = 1'b0; C = 1'b0; D = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(4'(1 << i), "data_g");
      step(4'(1 << i), "data_y");
      chk("data_y_val", {3'b000, Y}, {3'b000, i == 0 || i == 3});
      step(4'b0000, "data_rel");
    end

    // Random traffic with occasional resets
    mid_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      A = 1'($urandom); B = 1'($urandom);
      C = 1'($urandom); D = 1'($urandom);
      if ($urandom_range(0, 59) == 0) mid_reset("rand_rst");
      else step(4'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
